// File: rtl/vga_timing_gen.sv
// Raster timing generator: hs/vs, pixel coordinates, display enable and end-of-frame strobe.
// Optional VGA_TIMING_PIX_DIV_EN: internal divide-by-2 pixel enable replaces pix_en.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic        hs,
    output logic        vs,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic        frame_end
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        adv;
    logic [10:0] x_nxt, y_nxt;

`ifdef VGA_TIMING_PIX_DIV_EN
    // Toggle is 0 on the first edge after reset, so the first advance lands on the 2nd edge.
    logic tog;
    logic unused_pix_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tog <= 1'b0;
        else      tog <= ~tog;
    end

    assign adv           = tog;
    assign unused_pix_en = pix_en;
`else
    assign adv = pix_en;
`endif

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (adv) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 11'd1;
            end else begin
                x_nxt = x + 11'd1;
            end
        end
    end

    // Decode from the next counts so registered sync/de line up with the registered x/y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x         <= '0;
            y         <= '0;
            hs        <= ~H_POL;
            vs        <= ~V_POL;
            de        <= 1'b1;
            frame_end <= 1'b0;
        end else begin
            x         <= x_nxt;
            y         <= y_nxt;
            hs        <= (x_nxt >= HS_START && x_nxt < HS_END) ? H_POL : ~H_POL;
            vs        <= (y_nxt >= VS_START && y_nxt < VS_END) ? V_POL : ~V_POL;
            de        <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
            frame_end <= (x_nxt == H_LAST) && (y_nxt == V_LAST);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a 640x480 instance for line/hold/reset timing, and a small
// positive-polarity instance (32x19 total) so whole frames fit in a short run.
module tb_vga_timing_gen;
    localparam int HT_A = 800, VT_A = 525;
    localparam int HT_B = 32,  VT_B = 19;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fe;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en_a = 1'b0, pix_en_b = 1'b0;
    logic        hs_a, vs_a, de_a, fe_a, hs_b, vs_b, de_b, fe_b;
    logic [10:0] x_a, y_a, x_b, y_b;

    int    checks = 0, errors = 0;
    int    ax, ay, bx, by;
    bit    tog_m;
    pair_t sb[$];

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_en(pix_en_a),
        .hs(hs_a), .vs(vs_a), .x(x_a), .y(y_a), .de(de_a), .frame_end(fe_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_en_b),
        .hs(hs_b), .vs(vs_b), .x(x_b), .y(y_b), .de(de_b), .frame_end(fe_b)
    );

    function automatic exp_t calc(input int cx, input int cy, input int ha, input int hf,
                                  input int hw, input int hb, input int va, input int vf,
                                  input int vw, input int vb, input logic hp, input logic vp);
        exp_t e;
        e.x  = 11'(cx);
        e.y  = 11'(cy);
        e.hs = (cx >= ha + hf && cx < ha + hf + hw) ? hp : ~hp;
        e.vs = (cy >= va + vf && cy < va + vf + vw) ? vp : ~vp;
        e.de = (cx < ha) && (cy < va);
        e.fe = (cx == ha + hf + hw + hb - 1) && (cy == va + vf + vw + vb - 1);
        return e;
    endfunction

    function automatic pair_t expect_now();
        pair_t p;
        p.a = calc(ax, ay, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        p.b = calc(bx, by, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1, 1'b1);
        return p;
    endfunction

    function automatic pair_t observe();
        pair_t p;
        p.a.x = x_a; p.a.y = y_a; p.a.hs = hs_a; p.a.vs = vs_a; p.a.de = de_a; p.a.fe = fe_a;
        p.b.x = x_b; p.b.y = y_b; p.b.hs = hs_b; p.b.vs = vs_b; p.b.de = de_b; p.b.fe = fe_b;
        return p;
    endfunction

    task automatic model_adv(inout int cx, inout int cy, input int ht, input int vt);
        if (cx == ht - 1) begin
            cx = 0;
            cy = (cy == vt - 1) ? 0 : cy + 1;
        end else begin
            cx = cx + 1;
        end
    endtask

    task automatic model_reset();
        ax = 0; ay = 0; bx = 0; by = 0;
        tog_m = 1'b0;
        sb.delete();
    endtask

    // Drive one clk edge and queue the expected post-edge outputs.
    task automatic step(input logic pa, input logic pb);
        logic adv_a, adv_b;
        pix_en_a = pa;
        pix_en_b = pb;
`ifdef VGA_TIMING_PIX_DIV_EN
        adv_a = tog_m;
        adv_b = tog_m;
        tog_m = ~tog_m;
`else
        adv_a = pa;
        adv_b = pb;
`endif
        if (adv_a) model_adv(ax, ay, HT_A, VT_A);
        if (adv_b) model_adv(bx, by, HT_B, VT_B);
        sb.push_back(expect_now());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pair_t e, g;
        #2 rst = 1'b0;
        #2;
        model_reset();
        sb.push_back(expect_now());
        e = sb.pop_front();
        g = observe();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", g, e);
        end
        checks++;
        if ({x_a, y_a, hs_a, vs_a, de_a, fe_a} !== {22'd0, 4'b1110} ||
            {x_b, y_b, hs_b, vs_b, de_b, fe_b} !== {22'd0, 4'b0010}) begin
            errors++;
            $display("FAIL reset_const got a=%h b=%h", {x_a, y_a, hs_a, vs_a, de_a, fe_a},
                     {x_b, y_b, hs_b, vs_b, de_b, fe_b});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_line();
        pair_t e, g;
        int hs_cnt = 0, hs_first = -1, hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b1);
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL line_step%0d got %h exp %h", i, g, e);
            end
            if (hs_a === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
        end
        checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL hs_window got cnt=%0d first=%0d last=%0d exp 96/656/751",
                     hs_cnt, hs_first, hs_last);
        end
        checks++;
        if (x_a !== 11'd0 || y_a !== 11'd1) begin
            errors++;
            $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=1", x_a, y_a);
        end
    endtask

    task automatic test_frame();
        pair_t e, g;
        int de_cnt = 0, vs_cnt = 0, xbad = 0, edge_bad = 0, edge_seen = 0, guard = 0;
        int fe_pos[$];
        logic prev_fe = 1'b0;
        for (int i = 0; i < 2 * 608; i++) begin
            step(1'b0, 1'b1);
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL frame_step%0d got %h exp %h", i, g, e);
            end
            if (i < 608) begin
                if (de_b === 1'b1) de_cnt++;
                if (vs_b === 1'b1) vs_cnt++;
            end
            if (fe_b === 1'b1 && prev_fe !== 1'b1) fe_pos.push_back(i);
            prev_fe = fe_b;
            if ($isunknown({hs_a, vs_a, de_a, hs_b, vs_b, de_b})) xbad++;
            if (x_b == 11'd16 || y_b == 11'd12) begin
                edge_seen++;
                if (de_b !== 1'b0) edge_bad++;
            end
        end
        checks++;
        if (de_cnt != 192 || vs_cnt != 64) begin
            errors++;
            $display("FAIL frame_counts got de=%0d vs=%0d exp de=192 vs=64", de_cnt, vs_cnt);
        end
        checks++;
        if (fe_pos.size() != 2 || (fe_pos.size() == 2 && fe_pos[1] - fe_pos[0] != 608)) begin
            errors++;
            $display("FAIL frame_end_spacing got n=%0d exp n=2 spacing 608", fe_pos.size());
        end
        checks++;
        if (xbad != 0 || edge_bad != 0 || edge_seen == 0) begin
            errors++;
            $display("FAIL de_boundary got xbad=%0d edge_bad=%0d seen=%0d exp 0/0/>0",
                     xbad, edge_bad, edge_seen);
        end
        // Park on frame_end and verify it holds while the pixel enable is low.
        while (fe_b !== 1'b1 && guard < 700) begin
            step(1'b0, 1'b1);
            void'(sb.pop_front());
            guard++;
        end
        checks++;
        if (fe_b !== 1'b1 || x_b !== 11'd31 || y_b !== 11'd18) begin
            errors++;
            $display("FAIL frame_end_reach got fe=%b x=%0d y=%0d exp 1/31/18", fe_b, x_b, y_b);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        e = sb.pop_back();
        sb.delete();
        checks++;
        if (fe_b !== 1'b1 || observe() !== e) begin
            errors++;
            $display("FAIL frame_end_hold got fe=%b exp 1", fe_b);
        end
        step(1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (fe_b !== 1'b0 || x_b !== 11'd0 || y_b !== 11'd0 || observe() !== e) begin
            errors++;
            $display("FAIL frame_wrap got fe=%b x=%0d y=%0d exp 0/0/0", fe_b, x_b, y_b);
        end
    endtask

    task automatic test_hold();
        pair_t e, g, snap;
        for (int i = 0; i < 4900; i++) begin
            step(1'b1, 1'b0);
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL advance_step%0d got %h exp %h", i, g, e);
            end
        end
        snap = observe();
        checks++;
        if (x_a !== 11'd100 || y_a !== 11'd7) begin
            errors++;
            $display("FAIL hold_start got x=%0d y=%0d exp 100/7", x_a, y_a);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front();
            g = observe();
            checks++;
            if (g !== e || g !== snap) begin
                errors++;
                $display("FAIL hold_cycle%0d got %h exp %h", i, g, e);
            end
        end
        step(1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (x_a !== 11'd101 || y_a !== 11'd7 || observe() !== e) begin
            errors++;
            $display("FAIL hold_resume got x=%0d y=%0d exp 101/7", x_a, y_a);
        end
    endtask

    task automatic test_reset_mid();
        pair_t e;
        for (int i = 0; i < 199; i++) begin
            step(1'b1, 1'b1);
            void'(sb.pop_front());
        end
        checks++;
        if (x_a !== 11'd300 || y_a !== 11'd7) begin
            errors++;
            $display("FAIL pre_reset got x=%0d y=%0d exp 300/7", x_a, y_a);
        end
        rst = 1'b0;
        #2;
        checks++;
        if ({x_a, y_a, hs_a, vs_a, de_a, fe_a} !== {22'd0, 4'b1110} ||
            {x_b, y_b, hs_b, vs_b, de_b, fe_b} !== {22'd0, 4'b0010}) begin
            errors++;
            $display("FAIL async_reset got a=%h b=%h", {x_a, y_a, hs_a, vs_a, de_a, fe_a},
                     {x_b, y_b, hs_b, vs_b, de_b, fe_b});
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b1);
        e = sb.pop_front();
        checks++;
        if (x_a !== 11'd1 || y_a !== 11'd0 || x_b !== 11'd1 || observe() !== e) begin
            errors++;
            $display("FAIL first_advance got xa=%0d ya=%0d xb=%0d exp 1/0/1", x_a, y_a, x_b);
        end
    endtask

    task automatic test_div();
        pair_t e;
        int exp_x[4] = '{0, 1, 1, 2};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (x_a !== 11'(exp_x[i]) || x_b !== 11'(exp_x[i]) || observe() !== e) begin
                errors++;
                $display("FAIL div_edge%0d got xa=%0d xb=%0d exp %0d", i + 1, x_a, x_b, exp_x[i]);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef VGA_TIMING_PIX_DIV_EN
        test_div();
`else
        test_line();
        test_frame();
        test_hold();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
